// File: rtl/vga_pkg.sv
// Shared timing defaults, pixel payload and streamer state encoding for the VGA pixel streamer.
package vga_pkg;

  localparam int unsigned DEF_HDISP  = 640;
  localparam int unsigned DEF_HFP    = 16;
  localparam int unsigned DEF_HPULSE = 96;
  localparam int unsigned DEF_HBP    = 48;
  localparam int unsigned DEF_VDISP  = 480;
  localparam int unsigned DEF_VFP    = 11;
  localparam int unsigned DEF_VPULSE = 2;
  localparam int unsigned DEF_VBP    = 31;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    STREAM = 2'd2
  } state_t;

endpackage

// File: rtl/vga_pixel_stream_if.sv
// First-word-fall-through FIFO read port between the framebuffer FIFO and the pixel streamer.
interface vga_pixel_stream_if;
  import vga_pkg::*;

  rgb_t fifo_rdata;
  logic fifo_empty;
  logic fifo_full;
  logic fifo_read;

  modport master (output fifo_rdata, output fifo_empty, output fifo_full, input fifo_read);
  modport slave  (input fifo_rdata, input fifo_empty, input fifo_full, output fifo_read);
endinterface

// File: rtl/vga_timing_cnt.sv
// Raster position counters with active-area, sync and frame-boundary decodes.
module vga_timing_cnt
  import vga_pkg::*;
#(
  parameter int unsigned HDISP  = DEF_HDISP,
  parameter int unsigned HFP    = DEF_HFP,
  parameter int unsigned HPULSE = DEF_HPULSE,
  parameter int unsigned HBP    = DEF_HBP,
  parameter int unsigned VDISP  = DEF_VDISP,
  parameter int unsigned VFP    = DEF_VFP,
  parameter int unsigned VPULSE = DEF_VPULSE,
  parameter int unsigned VBP    = DEF_VBP,
  parameter int unsigned PXW    = $clog2(HDISP),
  parameter int unsigned PYW    = $clog2(VDISP)
) (
  input  logic           clk,
  input  logic           nrst,
  input  logic           hold_c,
  output logic           active_c,
  output logic           hs_n_c,
  output logic           vs_n_c,
  output logic           frame_wrap_c,
  output logic           frame_origin_c,
  output logic [PXW-1:0] col_c,
  output logic [PYW-1:0] row_c
);

  localparam int unsigned HTOTAL = HDISP + HFP + HPULSE + HBP;
  localparam int unsigned VTOTAL = VDISP + VFP + VPULSE + VBP;
  localparam int unsigned HW     = $clog2(HTOTAL);
  localparam int unsigned VW     = $clog2(VTOTAL);
  localparam int unsigned HS_LO  = HDISP + HFP;
  localparam int unsigned HS_HI  = HS_LO + HPULSE;
  localparam int unsigned VS_LO  = VDISP + VFP;
  localparam int unsigned VS_HI  = VS_LO + VPULSE;

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic [31:0]   h_ext_c, v_ext_c;
  logic          h_last_c, v_last_c;

  // Decodes compare in 32 bits so a porch of zero cannot alias a window edge to 0.
  assign h_ext_c        = 32'(hcnt_q);
  assign v_ext_c        = 32'(vcnt_q);
  assign h_last_c       = (h_ext_c == HTOTAL - 1);
  assign v_last_c       = (v_ext_c == VTOTAL - 1);
  assign active_c       = (h_ext_c < HDISP) && (v_ext_c < VDISP);
  assign hs_n_c         = !((h_ext_c >= HS_LO) && (h_ext_c < HS_HI));
  assign vs_n_c         = !((v_ext_c >= VS_LO) && (v_ext_c < VS_HI));
  assign frame_wrap_c   = h_last_c && v_last_c;
  assign frame_origin_c = (hcnt_q == '0) && (vcnt_q == '0);
  assign col_c          = PXW'(hcnt_q);
  assign row_c          = PYW'(vcnt_q);

  always_comb begin : cnt_next
    hcnt_d = hcnt_q + HW'(1);
    vcnt_d = vcnt_q;
    if (hold_c) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end else if (h_last_c) begin
      hcnt_d = '0;
      vcnt_d = v_last_c ? '0 : vcnt_q + VW'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin : cnt_regs
    if (!nrst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

endmodule

// File: rtl/vga_pixel_stream.sv
// 640x480 VGA timing plus FWFT pixel streamer; arms on a full FIFO at a frame boundary.
module vga_pixel_stream
  import vga_pkg::*;
#(
  parameter int unsigned HDISP  = DEF_HDISP,
  parameter int unsigned HFP    = DEF_HFP,
  parameter int unsigned HPULSE = DEF_HPULSE,
  parameter int unsigned HBP    = DEF_HBP,
  parameter int unsigned VDISP  = DEF_VDISP,
  parameter int unsigned VFP    = DEF_VFP,
  parameter int unsigned VPULSE = DEF_VPULSE,
  parameter int unsigned VBP    = DEF_VBP,
  localparam int unsigned PXW   = $clog2(HDISP),
  localparam int unsigned PYW   = $clog2(VDISP)
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                en,
  vga_pixel_stream_if.slave   fifo,
  output logic                vga_hs,
  output logic                vga_vs,
  output logic                vga_blank_n,
  output rgb_t                vga_rgb,
  output logic [PXW-1:0]      pix_x,
  output logic [PYW-1:0]      pix_y,
  output logic                frame_start,
  output logic                underflow,
  input  logic                clr_underflow
);

  state_t           state_q, state_d;
  logic             active_c, hs_n_c, vs_n_c, frame_wrap_c, frame_origin_c;
  logic             hold_c, pix_ok_c, read_c;
  logic [PXW-1:0]   col_c;
  logic [PYW-1:0]   row_c;
  logic             hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
  rgb_t             rgb_q, rgb_d;
  logic [PXW-1:0]   pix_x_q, pix_x_d;
  logic [PYW-1:0]   pix_y_q, pix_y_d;
  logic             frame_start_q, frame_start_d, underflow_q, underflow_d;

  vga_timing_cnt #(
    .HDISP (HDISP), .HFP (HFP), .HPULSE (HPULSE), .HBP (HBP),
    .VDISP (VDISP), .VFP (VFP), .VPULSE (VPULSE), .VBP (VBP),
    .PXW   (PXW),   .PYW (PYW)
  ) u_timing (
    .clk            (clk),
    .nrst           (nrst),
    .hold_c         (hold_c),
    .active_c       (active_c),
    .hs_n_c         (hs_n_c),
    .vs_n_c         (vs_n_c),
    .frame_wrap_c   (frame_wrap_c),
    .frame_origin_c (frame_origin_c),
    .col_c          (col_c),
    .row_c          (row_c)
  );

  // Counters sit at the origin while idle, including the edge that enters IDLE.
  assign hold_c         = (state_q == IDLE) || (state_d == IDLE);
  assign pix_ok_c       = (state_q == STREAM) && active_c;
  assign read_c         = pix_ok_c && !fifo.fifo_empty;
  assign fifo.fifo_read = read_c;

  always_comb begin : fsm_next
    state_d       = state_q;
    hs_d          = hs_n_c;
    vs_d          = vs_n_c;
    blank_n_d     = pix_ok_c;
    rgb_d         = read_c ? fifo.fifo_rdata : '0;
    pix_x_d       = active_c ? col_c : pix_x_q;
    pix_y_d       = active_c ? row_c : pix_y_q;
    frame_start_d = (state_q != IDLE) && frame_origin_c;
    underflow_d   = underflow_q;
    if (clr_underflow) underflow_d = 1'b0;
    if (pix_ok_c && fifo.fifo_empty) underflow_d = 1'b1;

    unique case (state_q)
      IDLE:    if (en) state_d = ARM;
      ARM: begin
        if (!en)                                state_d = IDLE;
        else if (frame_wrap_c && fifo.fifo_full) state_d = STREAM;
      end
      STREAM:  if (frame_wrap_c && !en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin : out_regs
    if (!nrst) begin
      state_q       <= IDLE;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_n_q     <= 1'b0;
      rgb_q         <= '0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= blank_n_d;
      rgb_q         <= rgb_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      frame_start_q <= frame_start_d;
      underflow_q   <= underflow_d;
    end
  end

  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
  assign vga_rgb     = rgb_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign frame_start = frame_start_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_vga_pixel_stream.sv
// Bench for vga_pixel_stream on a reduced raster, checked against a linear frame-position model.
module tb_vga_pixel_stream;
  import vga_pkg::*;

  localparam int HD = 20, HF = 3, HP = 5, HB = 4;
  localparam int VD = 10, VF = 2, VP = 3, VB = 2;
  localparam int HT = HD + HF + HP + HB;
  localparam int VT = VD + VF + VP + VB;
  localparam int FRAME = HT * VT;
  localparam int PXW = $clog2(HD);
  localparam int PYW = $clog2(VD);

  logic clk = 1'b0;
  logic nrst, en, clr;
  logic hs, vs, bn, fs, uf;
  rgb_t rgb;
  logic [PXW-1:0] px;
  logic [PYW-1:0] py;

  vga_pixel_stream_if fif();

  vga_pixel_stream #(
    .HDISP(HD), .HFP(HF), .HPULSE(HP), .HBP(HB),
    .VDISP(VD), .VFP(VF), .VPULSE(VP), .VBP(VB)
  ) dut (
    .clk(clk), .nrst(nrst), .en(en), .fifo(fif),
    .vga_hs(hs), .vga_vs(vs), .vga_blank_n(bn), .vga_rgb(rgb),
    .pix_x(px), .pix_y(py), .frame_start(fs), .underflow(uf),
    .clr_underflow(clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: mode 0 idle, 1 armed, 2 streaming; mp is the linear position within the frame.
  int   ms, mp;
  logic e_hs, e_vs, e_bn, e_fs, e_uf;
  rgb_t e_rgb;
  int   e_px, e_py;
  logic last_read;
  bit   incr_mode;
  logic [23:0] data_ctr;
  int   n_pop, n_hs_low, n_vs_low, n_bn, n_fs;

  typedef struct {
    logic en, empty, full, clr;
    logic [23:0] rdata;
    logic exp_hs, exp_vs, exp_bn;
    logic [23:0] exp_rgb;
    logic exp_read, exp_fs;
  } vec_t;
  vec_t tbl [9];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic bit in_win(int x, int lo, int len);
    return (x >= lo) && (x < lo + len);
  endfunction

  task automatic model_reset();
    ms = 0; mp = 0;
    e_hs = 1; e_vs = 1; e_bn = 0; e_rgb = '0; e_px = 0; e_py = 0; e_fs = 0; e_uf = 0;
  endtask

  task automatic clr_acc();
    n_pop = 0; n_hs_low = 0; n_vs_low = 0; n_bn = 0; n_fs = 0;
  endtask

  // One pixel clock: check the pop strobe, advance the model across the edge, check outputs.
  task automatic cyc();
    int h, v, nms;
    bit act, wrap, rd;
    #1;
    h = mp % HT;
    v = mp / HT;
    act = (h < HD) && (v < VD);
    wrap = (mp == FRAME - 1);
    rd = (ms == 2) && act && !fif.fifo_empty;
    last_read = fif.fifo_read;
    if (last_read === 1'b1) n_pop++;
    chk("fifo_read", 32'(fif.fifo_read), 32'(rd));
    @(posedge clk);
    e_hs = !in_win(h, HD + HF, HP);
    e_vs = !in_win(v, VD + VF, VP);
    e_bn = (ms == 2) && act;
    e_rgb = rd ? fif.fifo_rdata : '0;
    if (act) begin e_px = h; e_py = v; end
    e_fs = (ms != 0) && (mp == 0);
    if ((ms == 2) && act && fif.fifo_empty) e_uf = 1;
    else if (clr) e_uf = 0;
    case (ms)
      0:       nms = en ? 1 : 0;
      1:       nms = !en ? 0 : ((wrap && fif.fifo_full) ? 2 : 1);
      default: nms = (wrap && !en) ? 0 : 2;
    endcase
    mp = (ms == 0 || nms == 0) ? 0 : (mp + 1) % FRAME;
    ms = nms;
    if (incr_mode && rd) data_ctr = data_ctr + 24'd1;
    @(negedge clk);
    if (incr_mode) fif.fifo_rdata = data_ctr;
    chk("vga_hs", 32'(hs), 32'(e_hs));
    chk("vga_vs", 32'(vs), 32'(e_vs));
    chk("vga_blank_n", 32'(bn), 32'(e_bn));
    chk("vga_rgb", 32'(rgb), 32'(e_rgb));
    chk("pix_x", 32'(px), 32'(e_px));
    chk("pix_y", 32'(py), 32'(e_py));
    chk("frame_start", 32'(fs), 32'(e_fs));
    chk("underflow", 32'(uf), 32'(e_uf));
    if (hs === 1'b0) n_hs_low++;
    if (vs === 1'b0) n_vs_low++;
    if (bn === 1'b1) n_bn++;
    if (fs === 1'b1) n_fs++;
  endtask

  task automatic run(int n);
    repeat (n) cyc();
  endtask

  task automatic goto_pos(int target);
    for (int i = 0; i < 2 * FRAME && mp != target; i++) cyc();
  endtask

  task automatic wait_blank(int limit, output int k);
    k = 0;
    while (bn !== 1'b1 && k < limit) begin
      cyc();
      k++;
    end
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_hs"}, 32'(hs), 32'(1));
    chk({tag, "_vs"}, 32'(vs), 32'(1));
    chk({tag, "_blank_n"}, 32'(bn), 32'(0));
    chk({tag, "_rgb"}, 32'(rgb), 32'(0));
    chk({tag, "_pix_x"}, 32'(px), 32'(0));
    chk({tag, "_pix_y"}, 32'(py), 32'(0));
    chk({tag, "_frame_start"}, 32'(fs), 32'(0));
    chk({tag, "_underflow"}, 32'(uf), 32'(0));
    chk({tag, "_fifo_read"}, 32'(fif.fifo_read), 32'(0));
  endtask

  initial begin
    int k, mp0;
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b1, 1'b0, 24'h0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 24'hffffff, 1'b1, 1'b1, 1'b0, 24'h0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 24'h123456, 1'b1, 1'b1, 1'b0, 24'h0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 24'ha5a5a5, 1'b1, 1'b1, 1'b0, 24'h0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 24'h000001, 1'b1, 1'b1, 1'b0, 24'h0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 24'h800000, 1'b1, 1'b1, 1'b0, 24'h0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b1, 1'b0, 24'h0, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b1, 1'b0, 24'h0, 1'b0, 1'b1};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b1, 1'b0, 24'h0, 1'b0, 1'b0};

    en = 0; clr = 0; incr_mode = 0; data_ctr = '0;
    fif.fifo_rdata = '0; fif.fifo_empty = 1; fif.fifo_full = 0;
    nrst = 1;
    model_reset();
    clr_acc();
    #3 nrst = 0;
    #1 chk_reset("reset");
    @(negedge clk);
    @(negedge clk);
    nrst = 1;

    // Disabled: outputs idle for 2000 cycles whatever the FIFO says.
    fif.fifo_empty = 0; fif.fifo_full = 1;
    run(2000);
    chk("idle_pops", 32'(n_pop), 32'(0));
    chk("idle_hs_low", 32'(n_hs_low), 32'(0));

    for (int i = 0; i < 9; i++) begin
      en = tbl[i].en; fif.fifo_empty = tbl[i].empty; fif.fifo_full = tbl[i].full;
      clr = tbl[i].clr; fif.fifo_rdata = tbl[i].rdata;
      cyc();
      chk("tbl_hs", 32'(hs), 32'(tbl[i].exp_hs));
      chk("tbl_vs", 32'(vs), 32'(tbl[i].exp_vs));
      chk("tbl_blank_n", 32'(bn), 32'(tbl[i].exp_bn));
      chk("tbl_rgb", 32'(rgb), 32'(tbl[i].exp_rgb));
      chk("tbl_read", 32'(last_read), 32'(tbl[i].exp_read));
      chk("tbl_frame_start", 32'(fs), 32'(tbl[i].exp_fs));
    end
    clr = 0;

    // Armed without a full FIFO: syncs run, no video, no pops.
    incr_mode = 1; data_ctr = '0; fif.fifo_rdata = '0;
    clr_acc();
    run(FRAME);
    chk("arm_hs_low", 32'(n_hs_low), 32'(HP * VT));
    chk("arm_vs_low", 32'(n_vs_low), 32'(VP * HT));
    chk("arm_blank_n", 32'(n_bn), 32'(0));
    chk("arm_pops", 32'(n_pop), 32'(0));
    chk("arm_frame_start", 32'(n_fs), 32'(1));
    run(FRAME / 2);
    mp0 = mp;
    fif.fifo_full = 1;
    wait_blank(2 * FRAME, k);
    chk("arm_to_stream_latency", 32'(k), 32'(FRAME - mp0 + 1));

    // Full-frame streaming of an incrementing FWFT source.
    clr_acc();
    run(FRAME);
    chk("frame_pops", 32'(n_pop), 32'(HD * VD));
    chk("frame_blank_n", 32'(n_bn), 32'(HD * VD));
    chk("frame_hs_low", 32'(n_hs_low), 32'(HP * VT));
    chk("frame_vs_low", 32'(n_vs_low), 32'(VP * HT));
    chk("pop_words", 32'(data_ctr), 32'(HD * VD + 1));

    // Five-pixel underflow mid-line, then flag clear.
    goto_pos(3 * HT + 5);
    clr_acc();
    fif.fifo_empty = 1;
    run(5);
    fif.fifo_empty = 0;
    chk("uflow_pops", 32'(n_pop), 32'(0));
    chk("uflow_rgb", 32'(rgb), 32'(0));
    chk("uflow_blank_n", 32'(bn), 32'(1));
    chk("uflow_flag", 32'(uf), 32'(1));
    run(1);
    chk("uflow_resume_pop", 32'(n_pop), 32'(1));
    chk("uflow_resume_px", 32'(px), 32'(10));
    clr = 1; run(1); clr = 0;
    chk("uflow_cleared", 32'(uf), 32'(0));
    goto_pos(4 * HT + 2);
    fif.fifo_empty = 1; clr = 1;
    run(1);
    fif.fifo_empty = 0; clr = 0;
    chk("set_beats_clear", 32'(uf), 32'(1));
    clr = 1; run(1); clr = 0;
    chk("clear_after_set", 32'(uf), 32'(0));
    goto_pos(5 * HT + HD);
    fif.fifo_empty = 1;
    run(4);
    fif.fifo_empty = 0;
    chk("blank_empty_no_flag", 32'(uf), 32'(0));

    // Disable mid-frame: the frame finishes, then the block goes idle.
    goto_pos(2 * HT);
    en = 0;
    clr_acc();
    run(FRAME - 2 * HT);
    chk("drain_pops", 32'(n_pop), 32'(HD * (VD - 2)));
    clr_acc();
    run(FRAME);
    chk("off_pops", 32'(n_pop), 32'(0));
    chk("off_hs_low", 32'(n_hs_low), 32'(0));
    chk("off_frame_start", 32'(n_fs), 32'(0));

    // Re-arm, inject an underflow, then reset mid-frame.
    en = 1;
    wait_blank(3 * FRAME, k);
    chk("rearm_blank_n", 32'(bn), 32'(1));
    goto_pos(5 * HT + 3);
    fif.fifo_empty = 1; run(1); fif.fifo_empty = 0;
    goto_pos(5 * HT + 10);
    chk("pre_reset_read", 32'(fif.fifo_read), 32'(1));
    #2 nrst = 0;
    #1 chk_reset("midframe_reset");
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    data_ctr = '0; fif.fifo_rdata = '0;
    nrst = 1;
    wait_blank(3 * FRAME, k);
    chk("post_reset_latency", 32'(k), 32'(FRAME + 2));
    clr_acc();
    run(FRAME);
    chk("post_reset_pops", 32'(n_pop), 32'(HD * VD));
    chk("post_reset_words", 32'(data_ctr), 32'(HD * VD + 1));

    // Randomized enable, FIFO state, data and clears.
    incr_mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) en = ~en;
      fif.fifo_empty = ($urandom_range(0, 4) == 0);
      fif.fifo_full  = ($urandom_range(0, 3) != 0);
      clr            = ($urandom_range(0, 15) == 0);
      fif.fifo_rdata = 24'($urandom());
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_pixel_stream.md
Name: vga_pixel_stream

Overview:
- Video timing generator plus pixel streamer, directly downstream of the framebuffer pixel FIFO and upstream of the board VGA DAC pins.
- Generates 640x480 raster timing (HS, VS, BLANK_n) on the pixel clock.
- Pops one 24-bit RGB word per active pixel from a first-word-fall-through FIFO and drives registered RGB.
- Arms only when the FIFO is full at a frame boundary; flags and survives underflow.

Parameters:
- HDISP, 640, active pixels per line
- HFP, 16, horizontal front porch (clocks)
- HPULSE, 96, HS pulse width
- HBP, 48, horizontal back porch
- VDISP, 480, active lines per frame
- VFP, 11, vertical front porch (lines)
- VPULSE, 2, VS pulse width
- VBP, 31, vertical back porch

Ports:
- clk  in  1  pixel clock (27 MHz aux clock domain)
- nrst  in  1  asynchronous active-low reset
- en  in  1  streaming enable, level
- fifo_rdata  in  24  FWFT head word {R,G,B}
- fifo_empty  in  1  FIFO empty
- fifo_full  in  1  FIFO full
- fifo_read  out  1  pop strobe, combinational
- vga_hs  out  1  horizontal sync, active low
- vga_vs  out  1  vertical sync, active low
- vga_blank_n  out  1  high during active video
- vga_rgb  out  24  pixel colour
- pix_x  out  $clog2(HDISP)  current active column
- pix_y  out  $clog2(VDISP)  current active line
- frame_start  out  1  one-cycle pulse at hcnt=0, vcnt=0
- underflow  out  1  sticky underflow flag
- clr_underflow  in  1  clears underflow

Behaviour:
- Clock and reset: single clock clk; reset nrst is asynchronous, active low. All flops reset asynchronously.
- Reset values: hcnt=0, vcnt=0, state=IDLE, vga_hs=1, vga_vs=1, vga_blank_n=0, vga_rgb=0, pix_x=0, pix_y=0, frame_start=0, underflow=0.
- Counters:
  - HTOTAL=HDISP+HFP+HPULSE+HBP (800); VTOTAL=VDISP+VFP+VPULSE+VBP (524).
  - hcnt runs 0..HTOTAL-1 and wraps to 0. vcnt increments on hcnt wrap; vcnt wraps at VTOTAL-1 to 0.
  - Counters run in every state except IDLE, where they are held at 0.
- Raster order per line: active [0,HDISP), front porch, HS pulse [HDISP+HFP, HDISP+HFP+HPULSE), back porch. Vertical follows the same order in lines.
- Decodes: active = hcnt<HDISP && vcnt<VDISP. HS and VS are low inside their pulse windows.
- Output timing: all video outputs are registered one cycle after the counter decode, so HS, VS, BLANK_n and RGB stay mutually aligned.
- State machine:
  - IDLE: en=1 -> ARM.
  - ARM: blanked output, sync pulses generated, no reads. At hcnt=HTOTAL-1, vcnt=VTOTAL-1 with fifo_full=1 -> STREAM.
  - STREAM: fifo_read = active && !fifo_empty. vga_rgb <= fifo_rdata when the pop occurs; otherwise 0.
  - Any state with en=0: STREAM completes the current frame, then -> IDLE at the frame wrap. ARM -> IDLE immediately.
- Underflow: active && fifo_empty in STREAM sets underflow. That pixel is output as 0 (black) and streaming continues.
  - clr_underflow clears the flag. If a set and a clear occur in the same cycle, the set wins.
- Outside active video: vga_rgb=0, vga_blank_n=0. pix_x and pix_y hold their last active values.
- frame_start pulses in ARM and STREAM only.
- Reset mid-frame: everything returns to reset values immediately. fifo_read drops to 0 combinationally.
- fifo_read is never asserted while fifo_empty=1 or while blanked.

Decomposition:
- Package vga_pkg holds:
  - timing defaults (HFP, HPULSE, HBP, VFP, VPULSE, VBP)
  - the rgb_t 24-bit struct
  - the state enum {IDLE, ARM, STREAM}
- Sub-module vga_timing_cnt contains hcnt/vcnt, the active, HS and VS decodes, and the frame-wrap strobe. The streaming FSM and output registers stay in the top.

Test Plan:
- Reset, en=0 -> HS=VS=1, blank_n=0, rgb=0, fifo_read=0 for 2000 cycles.
- en=1, fifo_full=1, fifo never empty -> first blank_n=1 one cycle after the first frame wrap. HS low exactly 96 clocks per 800-clock line. VS low exactly 2 lines per 524 lines. 307200 pops per frame.
- FWFT model incrementing data 0,1,2… -> vga_rgb sequence matches the pop order with 1-cycle latency. pix_x=0..639, pix_y=0..479.
- fifo_empty forced high for 5 active pixels mid-line -> rgb=0 for those 5 pixels, underflow=1, no pops during those cycles. Streaming resumes at pixel 6. clr_underflow clears the flag.
- en=1 with fifo_full=0 -> remains in ARM, blanked, syncs running. Raise fifo_full -> streaming starts at the next frame wrap only.
- nrst low at hcnt=300, vcnt=100 -> all outputs take reset values asynchronously. After release and en=1, the block re-arms and streams a full frame correctly.
